// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: instruction-memory read port plus the
// fetched-instruction valid/ready handshake toward decode.
interface fetch_queue_unit_if #(
  parameter int PC_W   = 10,
  parameter int INST_W = 9
);
  logic [PC_W-1:0]   ImemAddr;
  logic              ImemRdEn;
  logic [INST_W-1:0] ImemData;
  logic              InstValid;
  logic [INST_W-1:0] Inst;
  logic [PC_W-1:0]   InstPC;
  logic              InstReady;

  modport master (
    output ImemAddr, ImemRdEn,
    input  ImemData,
    output InstValid, Inst, InstPC,
    input  InstReady
  );

  modport slave (
    input  ImemAddr, ImemRdEn,
    output ImemData,
    input  InstValid, Inst, InstPC,
    output InstReady
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: PC, 1-cycle imem reads, prefetch queue.
// Ports: Clk, Reset (async low), Start/Redirect*/Halt controls,
//   bus (imem read port + Inst valid/ready), Count, Ack.
module fetch_queue_unit #(
  parameter int              PC_W       = 10,
  parameter int              INST_W     = 9,
  parameter int              DEPTH      = 4,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Redirect,
  input  logic                  RedirectRel,
  input  logic [PC_W-1:0]       RedirectPC,
  input  logic [PC_W-1:0]       Target,
  input  logic                  Halt,
  fetch_queue_unit_if.master    bus,
  output logic [$clog2(DEPTH):0] Count,
  output logic                  Ack
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN, HALTED
  } state_t;

  state_t state, state_nx;

  logic [PC_W-1:0]   pc, pc_nx, tgt;
  logic [PC_W-1:0]   fly_pc;
  logic              start_q, inflight;
  logic [INST_W-1:0] qi [DEPTH];
  logic [PC_W-1:0]   qp [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [INST_W-1:0] hold_i;
  logic [PC_W-1:0]   hold_p;
  logic              flush, issue, push, pop;
  logic              room, empty;

  assign tgt   = RedirectRel ? RedirectPC + Target : Target;
  assign empty = (count == '0);
  assign pop   = !empty && bus.InstReady;
  // A squashed in-flight read returns data that is simply dropped.
  assign push  = inflight && !flush;
  // Reserve a slot for the read already on its way back.
  assign room  = int'(count) + int'(inflight) + 1 <= DEPTH;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    issue    = 1'b0;
    flush    = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) pc_nx = START_ADDR;
        if (start_q && !Start) state_nx = FETCH;
      end
      FETCH, DRAIN: begin
        if (Start) begin
          flush    = 1'b1;
          pc_nx    = START_ADDR;
          state_nx = IDLE;
        end else if (Redirect) begin
          flush = 1'b1;
          pc_nx = tgt;
          if (Halt) state_nx = DRAIN;
        end else if (state == FETCH) begin
          if (Halt) begin
            state_nx = DRAIN;
          end else if (room) begin
            issue = 1'b1;
            pc_nx = pc + PC_W'(1);
          end
        end else if (empty && !inflight) begin
          state_nx = HALTED;
        end
      end
      HALTED: begin
        if (Start) begin
          pc_nx    = START_ADDR;
          state_nx = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      pc       <= '0;
      start_q  <= 1'b0;
      inflight <= 1'b0;
      fly_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      hold_i   <= '0;
      hold_p   <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      start_q  <= Start;
      inflight <= issue;
      fly_pc   <= pc;
      // Keeps the last presented head visible once the queue empties.
      if (!empty) begin
        hold_i <= qi[rd_ptr];
        hold_p <= qp[rd_ptr];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      qi[wr_ptr] <= bus.ImemData;
      qp[wr_ptr] <= fly_pc;
    end
  end

  assign bus.ImemAddr  = pc;
  assign bus.ImemRdEn  = issue;
  assign bus.InstValid = !empty;
  assign bus.Inst      = empty ? hold_i : qi[rd_ptr];
  assign bus.InstPC    = empty ? hold_p : qp[rd_ptr];
  assign Count         = count;
  assign Ack           = (state == HALTED);

  a_no_overflow: assert property (
    @(posedge Clk) disable iff (!Reset)
    !(push && !pop && count == CW'(DEPTH))
  );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed steps plus random
// backpressure/redirects against a program-order model.
module tb_fetch_queue_unit;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Redirect = 1'b0;
  logic       RedirectRel = 1'b0;
  logic [9:0] RedirectPC = '0;
  logic [9:0] Target = '0;
  logic       Halt = 1'b0;
  logic [2:0] Count;
  logic       Ack;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int rd_cnt = 0;
  logic [9:0] exp_pc = '0;

  fetch_queue_unit_if #(.PC_W(10), .INST_W(9)) bus ();

  fetch_queue_unit #(
    .PC_W(10), .INST_W(9), .DEPTH(4), .START_ADDR(10'd0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Redirect(Redirect), .RedirectRel(RedirectRel),
    .RedirectPC(RedirectPC), .Target(Target), .Halt(Halt),
    .bus(bus), .Count(Count), .Ack(Ack)
  );

  always #5 Clk = ~Clk;

  function automatic logic [8:0] memf(input logic [9:0] a);
    logic [9:0] s;
    s = a + 10'h100;
    return s[8:0];
  endfunction

  always @(posedge Clk) begin
    if (bus.ImemRdEn) bus.ImemData <= memf(bus.ImemAddr);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Program-order model: each accepted instruction must be the
  // next sequential PC; Start/Redirect restart the sequence.
  always @(negedge Clk) begin
    if (!Reset) begin
      exp_pc = 10'd0;
    end else begin
      if (bus.ImemRdEn) rd_cnt++;
      chk("count_le_depth", 32'(Count <= 3'd4), 32'd1);
      if (bus.InstValid && bus.InstReady) begin
        chk("pop_pc", 32'(bus.InstPC), 32'(exp_pc));
        chk("pop_inst", 32'(bus.Inst), 32'(memf(exp_pc)));
        exp_pc = exp_pc + 10'd1;
        pops++;
      end
      if (Start) exp_pc = 10'd0;
      else if (Redirect)
        exp_pc = RedirectRel ? RedirectPC + Target : Target;
    end
  end

  initial begin
    logic [9:0] tgt;
    logic [9:0] seq [4];
    int p0;
    seq[0] = 10'h3FE; seq[1] = 10'h3FF;
    seq[2] = 10'h000; seq[3] = 10'h001;
    bus.InstReady = 1'b1;
    bus.ImemData = '0;

    repeat (2) tick();
    chk("rst_count", 32'(Count), 0);
    chk("rst_valid", 32'(bus.InstValid), 0);
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_rden", 32'(bus.ImemRdEn), 0);
    chk("rst_addr", 32'(bus.ImemAddr), 0);
    chk("rst_inst", 32'(bus.Inst), 0);
    chk("rst_instpc", 32'(bus.InstPC), 0);

    Reset = 1'b1;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    chk("idle_rden", 32'(bus.ImemRdEn), 0);
    tick();
    chk("f0_rden", 32'(bus.ImemRdEn), 1);
    chk("f0_addr", 32'(bus.ImemAddr), 0);
    tick();
    chk("f1_addr", 32'(bus.ImemAddr), 1);
    chk("f1_valid", 32'(bus.InstValid), 0);
    tick();
    chk("first_valid", 32'(bus.InstValid), 1);
    chk("first_pc", 32'(bus.InstPC), 0);
    chk("first_inst", 32'(bus.Inst), 32'h100);
    repeat (12) begin
      tick();
      chk("thru_valid", 32'(bus.InstValid), 1);
      chk("thru_rden", 32'(bus.ImemRdEn), 1);
      chk("thru_count", 32'(Count), 1);
    end

    bus.InstReady = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    rd_cnt = 0;
    repeat (10) tick();
    chk("bp_reads", 32'(rd_cnt), 4);
    chk("bp_count", 32'(Count), 4);
    chk("bp_rden", 32'(bus.ImemRdEn), 0);
    chk("bp_head", 32'(bus.InstPC), 0);
    bus.InstReady = 1'b1;
    repeat (8) tick();

    Redirect = 1'b1;
    RedirectRel = 1'b1;
    RedirectPC = 10'd20;
    Target = 10'h3FC;
    #1;
    chk("rel_inflight", 32'(bus.ImemRdEn), 0);
    tick();
    Redirect = 1'b0;
    #1;
    chk("rel_count", 32'(Count), 0);
    chk("rel_addr", 32'(bus.ImemAddr), 16);
    chk("rel_rden", 32'(bus.ImemRdEn), 1);
    for (int i = 0; i < 6 && !bus.InstValid; i++) tick();
    chk("rel_first_pc", 32'(bus.InstPC), 16);

    Redirect = 1'b1;
    RedirectRel = 1'b0;
    Target = 10'h3FE;
    tick();
    Redirect = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", 32'(bus.ImemAddr), 32'(seq[i]));
      chk("wrap_rden", 32'(bus.ImemRdEn), 1);
      tick();
    end
    repeat (4) tick();

    for (int n = 0; n < 300; n++) begin
      tick();
      bus.InstReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        Redirect = 1'b1;
        RedirectRel = 1'($urandom);
        RedirectPC = 10'($urandom);
        Target = 10'($urandom);
        tgt = RedirectRel ? RedirectPC + Target : Target;
        #1;
        chk("rnd_redir_rden", 32'(bus.ImemRdEn), 0);
        tick();
        Redirect = 1'b0;
        #1;
        chk("rnd_flush", 32'(Count), 0);
        chk("rnd_tgt_rden", 32'(bus.ImemRdEn), 1);
        chk("rnd_tgt_addr", 32'(bus.ImemAddr), 32'(tgt));
      end
    end

    bus.InstReady = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 10 && Count != 3'd3; i++) tick();
    chk("halt_q3", 32'(Count), 3);
    Halt = 1'b1;
    bus.InstReady = 1'b1;
    p0 = pops;
    #1;
    chk("halt_rden", 32'(bus.ImemRdEn), 0);
    tick();
    Halt = 1'b0;
    for (int i = 0; i < 20 && !Ack; i++) begin
      chk("drain_rden", 32'(bus.ImemRdEn), 0);
      tick();
    end
    chk("halt_ack", 32'(Ack), 1);
    chk("halt_delivered", 32'(pops - p0), 4);
    tick();
    chk("halt_pc_frozen", 32'(bus.ImemAddr), 4);
    chk("halt_ack_hold", 32'(Ack), 1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    chk("restart_ack", 32'(Ack), 0);
    chk("restart_pc", 32'(bus.ImemAddr), 0);

    bus.InstReady = 1'b0;
    repeat (5) tick();
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    chk("arst_count", 32'(Count), 0);
    chk("arst_valid", 32'(bus.InstValid), 0);
    chk("arst_inst", 32'(bus.Inst), 0);
    chk("arst_instpc", 32'(bus.InstPC), 0);
    chk("arst_addr", 32'(bus.ImemAddr), 0);
    chk("arst_rden", 32'(bus.ImemRdEn), 0);
    chk("arst_ack", 32'(Ack), 0);
    tick();
    Reset = 1'b1;
    bus.InstReady = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_valid", 32'(bus.InstValid), 0);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    p0 = pops;
    repeat (10) tick();
    chk("post_rst_flow", 32'(pops - p0 >= 6), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end; successor to the ProgCtr/InstROM pairing.
- Owns the program counter and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers fetched instructions with their PCs in a DEPTH-entry prefetch queue, handing them to Ctrl/decode via a valid/ready handshake.
- Supports absolute or PC-relative redirect with flush, and a Halt/Ack drain sequence.

Parameters:
PC_W, 10, program counter and memory address width
INST_W, 9, instruction width
DEPTH, 4, prefetch queue entries (power of two, >=2)
START_ADDR, 0, PC loaded while Start is high

Ports:
Clk  input  1  clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  high: hold PC at START_ADDR; falling edge begins fetch
Redirect  input  1  one-cycle branch/jump request
RedirectRel  input  1  1: target = RedirectPC + Target (signed); 0: target = Target
RedirectPC  input  PC_W  PC of the redirecting instruction
Target  input  PC_W  absolute target or signed two's-complement offset
Halt  input  1  stop fetching and drain
ImemAddr  output  PC_W  instruction memory address
ImemRdEn  output  1  read strobe; ImemData is valid the following cycle
ImemData  input  INST_W  instruction memory read data
InstValid  output  1  queue head valid
Inst  output  INST_W  queue head instruction
InstPC  output  PC_W  PC of queue head
InstReady  input  1  consumer accepts head when InstValid&InstReady
Count  output  clog2(DEPTH)+1  occupied queue entries
Ack  output  1  high while in HALTED

Behaviour:
- Reset (Reset=0, async): state IDLE; PC=0; queue empty; in-flight flag cleared; ImemRdEn=0; ImemAddr=0; InstValid=0; Inst=0; InstPC=0; Count=0; Ack=0. Reset mid-operation discards queue and in-flight read.
- States: IDLE, FETCH, DRAIN, HALTED.
- IDLE: no reads. Start=1 loads PC=START_ADDR. Start 1->0 (registered previous value) moves to FETCH next cycle. Redirect is ignored.
- FETCH: ImemRdEn=1, ImemAddr=PC when Count + inflight + 1 <= DEPTH, i.e. a slot is reserved for the returning read. On issue, PC <= PC+1, mod 2^PC_W; wrap from 2^PC_W-1 to 0 is legal.
- Fill: a read issued in cycle N writes {ImemData, issued PC} into the queue at the edge ending cycle N+1, unless squashed.
- Back-to-back issue: a sustained 1 instr/cycle throughput is required when the consumer is always ready.
- Pop: InstValid&InstReady removes the head. Push and pop in the same cycle leave Count unchanged. The queue never overflows; an issue that would overflow is an implementation error and is flagged with an assertion.
- Empty queue: InstValid=0; Inst/InstPC hold their last value. No bypass: a fill is visible on InstValid the cycle after it is written.
- Redirect (FETCH or DRAIN):
  - Next-edge effects: queue flushed (Count=0); any in-flight read squashed (its data is not written); PC <= computed target.
  - A pop accepted in the same cycle still counts as consumed.
  - ImemRdEn is 0 in the redirect cycle. The first read at the target issues the next cycle.
  - Relative target arithmetic is PC_W-bit, wrapping.
- Halt in FETCH: go to DRAIN. No new reads; the in-flight read completes and is queued. Halt and Redirect in the same cycle: redirect takes effect (flush, PC update), then DRAIN.
- DRAIN: when Count=0 and no read in flight, go to HALTED.
- HALTED: Ack=1; PC frozen; no reads. Start=1 returns to IDLE (PC=START_ADDR); otherwise HALTED persists until Reset.
- Halt in IDLE: ignored.
- Start=1 while in FETCH/DRAIN: flush, squash in-flight read, enter IDLE with PC=START_ADDR.

Test Plan:
- Reset low 2 cycles, release, Start high 1 cycle then low; memory holds addr+0x100 pattern (9-bit), InstReady=1 -> ImemAddr 0,1,2,... one per cycle; first InstValid with InstPC=0 three cycles after Start falls; thereafter one instruction per cycle, in order.
- InstReady=0 from the start -> exactly 4 reads issued; Count saturates at 4; ImemRdEn stays 0. Raise InstReady -> pops resume with no lost or duplicated PC.
- Redirect with RedirectRel=1, RedirectPC=20, Target=0x3FC (-4) while a read is in flight -> Count=0 next cycle; squashed data never appears; next ImemAddr=16; first InstPC after flush is 16.
- Absolute redirect to 0x3FE -> fetch addresses 0x3FE, 0x3FF, 0x000, 0x001; InstPC sequence matches.
- Halt with 3 queued and 1 in flight, InstReady=1 -> 4 more instructions delivered, then Ack=1. Start pulse -> IDLE, Ack=0, PC=START_ADDR.
- Assert Reset=0 asynchronously mid-FETCH (between clock edges) -> all outputs zero immediately, without waiting for Clk; no stale instruction after release.
